// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: control/status bundle between decode and the PC sequencer.
// master drives the fetch controls and observes PC/status; slave is the sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned D = 9
);
    logic         start;
    logic         stall;
    logic         halt;
    logic         rel_jump;
    logic         abs_jump;
    logic         taken;
    logic         call;
    logic         ret;
    logic [D-1:0] target;
    logic [D-1:0] prog_ctr;
    logic         fetch_valid;
    logic         busy;
    logic         done;
    logic         stack_err;

    modport master (
        output start, stall, halt, rel_jump, abs_jump,
        output taken, call, ret, target,
        input  prog_ctr, fetch_valid, busy, done, stack_err
    );

    modport slave (
        input  start, stall, halt, rel_jump, abs_jump,
        input  taken, call, ret, target,
        output prog_ctr, fetch_valid, busy, done, stack_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, runs IDLE -> RUN -> DONE, picks next fetch address.
// Ports: clk, reset (async active-low), bus (fetch_sequencer_if.slave):
//   in  start/stall/halt/rel_jump/abs_jump/taken/call/ret/target
//   out prog_ctr/fetch_valid/busy/done/stack_err
// Optional macro CALL_STACK_EN adds a STACK_DEPTH-entry return-address stack;
// without it call is a plain jump, ret an increment and stack_err is 0.
module fetch_sequencer #(
    parameter int unsigned   D           = 9,
    parameter logic [D-1:0]  START_ADDR  = '0,
    parameter int unsigned   STACK_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [D-1:0] pc_inc;

    if (STACK_DEPTH < 1) begin : g_depth_chk
        $error("STACK_DEPTH must be at least 1");
    end

    assign pc_inc = pc_q + D'(1);

`ifdef CALL_STACK_EN
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [D-1:0]   stk [STACK_DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_m1;
    logic           err_q;
    logic           stk_full, stk_empty;
    logic [D-1:0]   ret_addr;
    logic           push, pop, err_set, clr_stack;

    // sp counts valid entries; top of stack lives at sp-1
    assign sp_m1     = sp_q - SPW'(1);
    assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);
    assign ret_addr  = stk[sp_m1[IW-1:0]];
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef CALL_STACK_EN
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;
        clr_stack = 1'b0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
`ifdef CALL_STACK_EN
                    clr_stack = 1'b1;
`endif
                end
            end
            RUN: begin
                // Fixed priority: halt > ret > call > abs > rel > increment
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = DONE;
                    end else if (bus.ret) begin
`ifdef CALL_STACK_EN
                        if (stk_empty) begin
                            pc_d    = pc_inc;
                            err_set = 1'b1;
                        end else begin
                            pc_d = ret_addr;
                            pop  = 1'b1;
                        end
`else
                        pc_d = pc_inc;
`endif
                    end else if (bus.call) begin
                        pc_d = bus.target;
`ifdef CALL_STACK_EN
                        // A full stack drops the return address but still jumps
                        if (stk_full) begin
                            err_set = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`endif
                    end else if (bus.abs_jump && bus.taken) begin
                        pc_d = bus.target;
                    end else if (bus.rel_jump && bus.taken) begin
                        pc_d = pc_q + bus.target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef CALL_STACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else if (clr_stack) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (push) begin
                sp_q <= sp_q + SPW'(1);
            end else if (pop) begin
                sp_q <= sp_m1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: sp alone defines what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            stk[sp_q[IW-1:0]] <= pc_inc;
        end
    end

    assign bus.stack_err = err_q;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.prog_ctr    = pc_q;
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.fetch_valid = (state_q == RUN) && !bus.stall;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed + random stimulus against a behavioural PC model.
// Works with or without CALL_STACK_EN; the model follows the same macro.
module tb_fetch_sequencer;
    localparam int unsigned  D     = 9;
    localparam logic [D-1:0] START = '0;
    localparam int unsigned  DEPTH = 4;
`ifdef CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    fetch_sequencer_if #(.D(D)) bus ();

    fetch_sequencer #(
        .D(D),
        .START_ADDR(START),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit           m_run;
    bit           m_done;
    bit           m_err;
    logic [D-1:0] m_pc;
    logic [D-1:0] m_stk[$];

    function automatic void m_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_pc   = START;
        m_stk.delete();
    endfunction

    // One clock edge worth of behaviour using the current inputs
    function automatic void m_edge();
        logic [D-1:0] nxt;
        nxt = m_pc + D'(1);
        if (!m_run) begin
            if (bus.start) begin
                m_run  = 1'b1;
                m_done = 1'b0;
                m_err  = 1'b0;
                m_pc   = START;
                m_stk.delete();
            end
        end else if (!bus.stall) begin
            if (bus.halt) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (bus.ret) begin
                if (STK && m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc = nxt;
                    if (STK) m_err = 1'b1;
                end
            end else if (bus.call) begin
                if (STK) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(nxt);
                    else m_err = 1'b1;
                end
                m_pc = bus.target;
            end else if (bus.abs_jump && bus.taken) begin
                m_pc = bus.target;
            end else if (bus.rel_jump && bus.taken) begin
                m_pc = m_pc + bus.target;
            end else begin
                m_pc = nxt;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(bus.prog_ctr), 32'(m_pc));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_run));
        chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
        chk({tag, ".fv"}, 32'(bus.fetch_valid), 32'(m_run && !bus.stall));
        chk({tag, ".err"}, 32'(bus.stack_err), 32'(m_err));
    endtask

    task automatic step(input string tag);
        m_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_in();
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.halt     = 1'b0;
        bus.rel_jump = 1'b0;
        bus.abs_jump = 1'b0;
        bus.taken    = 1'b0;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;
        bus.target   = '0;
    endtask

    task automatic jump(input logic [D-1:0] a);
        clear_in();
        bus.abs_jump = 1'b1;
        bus.taken    = 1'b1;
        bus.target   = a;
        step("jump");
        clear_in();
    endtask

    task automatic restart();
        clear_in();
        bus.start = 1'b1;
        step("restart");
        clear_in();
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        m_reset();
        #1 reset = 1'b0;
        #1;
        check_all("por");
        @(posedge clk);
        #1;
        check_all("por_held");
        reset = 1'b1;
        step("idle0");
        step("idle1");

        // start, 5 increments, halt
        bus.start = 1'b1;
        step("start");
        chk("start_pc", 32'(bus.prog_ctr), 32'h0);
        bus.start = 1'b0;
        repeat (5) step("seq");
        chk("seq_pc5", 32'(bus.prog_ctr), 32'h5);
        bus.halt = 1'b1;
        step("halt");
        chk("halt_done", 32'(bus.done), 32'h1);
        chk("halt_pc", 32'(bus.prog_ctr), 32'h5);
        bus.halt = 1'b0;
        step("done_hold");
        chk("done_hold_pc", 32'(bus.prog_ctr), 32'h5);

        // relative backward branch, then not-taken absolute
        restart();
        jump(9'h010);
        bus.rel_jump = 1'b1;
        bus.taken    = 1'b1;
        bus.target   = 9'h1FD;
        step("rel");
        chk("rel_pc", 32'(bus.prog_ctr), 32'h00D);
        bus.rel_jump = 1'b0;
        bus.abs_jump = 1'b1;
        bus.taken    = 1'b0;
        step("abs_nt");
        chk("abs_nt_pc", 32'(bus.prog_ctr), 32'h00E);

        // wrap and stall
        jump(9'h1FF);
        step("wrap");
        chk("wrap_pc", 32'(bus.prog_ctr), 32'h0);
        bus.stall    = 1'b1;
        bus.abs_jump = 1'b1;
        bus.taken    = 1'b1;
        bus.target   = 9'h055;
        repeat (3) begin
            step("stall");
            chk("stall_pc", 32'(bus.prog_ctr), 32'h0);
            chk("stall_fv", 32'(bus.fetch_valid), 32'h0);
        end
        clear_in();
        step("unstall");
        chk("unstall_pc", 32'(bus.prog_ctr), 32'h1);

        // call / ret
        jump(9'h020);
        bus.call   = 1'b1;
        bus.target = 9'h080;
        step("call");
        chk("call_pc", 32'(bus.prog_ctr), 32'h080);
        clear_in();
        bus.ret = 1'b1;
        step("ret");
        chk("ret_pc", 32'(bus.prog_ctr), STK ? 32'h021 : 32'h081);
        clear_in();

        // five nested calls into a four-deep stack
        for (int i = 0; i < 5; i++) begin
            bus.call   = 1'b1;
            bus.target = 9'h100 + 9'(i * 8);
            step("nest");
        end
        clear_in();
        chk("nest_err", 32'(bus.stack_err), STK ? 32'h1 : 32'h0);
        bus.ret = 1'b1;
        repeat (5) step("unwind");
        clear_in();

        // halt wins over ret and call
        restart();
        jump(9'h02F);
        bus.call   = 1'b1;
        bus.target = 9'h030;
        step("pre_call");
        bus.halt = 1'b1;
        bus.ret  = 1'b1;
        bus.call = 1'b1;
        bus.target = 9'h1AA;
        step("halt_prio");
        chk("halt_prio_done", 32'(bus.done), 32'h1);
        chk("halt_prio_pc", 32'(bus.prog_ctr), 32'h030);
        clear_in();

        // asynchronous reset mid-RUN while stalled
        restart();
        jump(9'h025);
        bus.stall = 1'b1;
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("arst_pc", 32'(bus.prog_ctr), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'h0);
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst_held");
        reset = 1'b1;
        clear_in();
        repeat (3) step("post_rst");
        chk("post_rst_busy", 32'(bus.busy), 32'h0);
        restart();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                #1;
                m_reset();
                check_all("rnd_rst");
                @(posedge clk);
                #1;
                reset = 1'b1;
            end else begin
                bus.start    = ($urandom_range(0, 2) == 0);
                bus.stall    = ($urandom_range(0, 3) == 0);
                bus.halt     = ($urandom_range(0, 29) == 0);
                bus.ret      = ($urandom_range(0, 5) == 0);
                bus.call     = ($urandom_range(0, 5) == 0);
                bus.abs_jump = ($urandom_range(0, 4) == 0);
                bus.rel_jump = ($urandom_range(0, 3) == 0);
                bus.taken    = ($urandom_range(0, 1) == 0);
                bus.target   = D'($urandom);
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer for the single-cycle core. It owns the PC register and steps the core from a start pulse to a halt. Each cycle it chooses the next fetch address from sequential increment, relative branch, absolute jump, call or return. It sits between the decode/branch-resolution logic and the instruction ROM address port, and reports `done` to the testbench/top level.

## Interface
- `D`, 9, PC and target width in bits
- `START_ADDR`, 0, address loaded on start and on reset
- `STACK_DEPTH`, 4, return-address stack entries (only used with `CALL_STACK_EN`)

- `clk`  input  1  clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `start`  input  1  begin program execution (level, sampled in IDLE/DONE)
- `stall`  input  1  freeze PC and ignore all control inputs this cycle
- `halt`  input  1  end program after current instruction
- `rel_jump`  input  1  relative branch request
- `abs_jump`  input  1  absolute jump request
- `taken`  input  1  branch condition result, qualifies `rel_jump`/`abs_jump`
- `call`  input  1  jump to `target` and push return address
- `ret`  input  1  jump to popped return address
- `target`  input  D  absolute address, or two's-complement offset for `rel_jump`
- `prog_ctr`  output  D  current fetch address (registered)
- `fetch_valid`  output  1  high in RUN while `stall`=0
- `busy`  output  1  high in RUN
- `done`  output  1  high in DONE
- `stack_err`  output  1  sticky: overflow or underflow occurred

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `prog_ctr`=START_ADDR. `start`=1 → RUN; `prog_ctr` reloaded to START_ADDR; `stack_err` and stack cleared.
- RUN, `stall`=1: no state or PC change; all control inputs ignored.
- RUN, `stall`=0: next PC is chosen by fixed priority; only the highest-priority asserted input has effect:
  1. `halt` → DONE, `prog_ctr` unchanged.
  2. `ret` → pop.
  3. `call` → push `prog_ctr`+1, PC=`target`.
  4. `abs_jump`&`taken` → PC=`target`.
  5. `rel_jump`&`taken` → PC=`prog_ctr`+signed(`target`).
  6. Otherwise PC=`prog_ctr`+1.
- Arithmetic is modulo 2^D. `prog_ctr`=2^D−1 with increment → 0. Relative offsets wrap silently.
- `rel_jump`/`abs_jump` with `taken`=0 → increment.
- DONE: `prog_ctr` held; `start`=1 → RUN exactly as from IDLE.
- `start` is ignored in RUN.
- Reset (any time, including mid-RUN or mid-stall): immediately IDLE, `prog_ctr`=START_ADDR, `fetch_valid`=`busy`=`done`=`stack_err`=0, stack emptied.

## Timing
- All outputs are registered except `fetch_valid` (= RUN & !`stall`).
- Controls are sampled on cycle N; the new `prog_ctr` is visible after the edge ending cycle N (1-cycle latency).
- `start` in IDLE at cycle N: `busy`=1 and `prog_ctr`=START_ADDR in cycle N+1.
- `halt` at cycle N: `done`=1 and `busy`=0 from N+1; `done` stays high until the next start.
- `stack_err` sets in the cycle after the offending request.

## Configuration
- `CALL_STACK_EN` defined: a STACK_DEPTH-entry LIFO of D-bit return addresses.
  - `call` when full: push discarded, jump still taken, `stack_err` set.
  - `ret` when empty: PC=`prog_ctr`+1, `stack_err` set.
  - Push and pop never occur in the same cycle, because `ret` has priority.
- `CALL_STACK_EN` undefined: no stack storage.
  - `call` behaves as an unconditional absolute jump.
  - `ret` behaves as increment.
  - `stack_err` is tied to 0.

## Test plan
- Reset low mid-RUN at `prog_ctr`=0x025 → `prog_ctr`=0x000 with no clock edge; `busy`=0; after release, stays IDLE until `start`.
- `start` pulse, 5 idle cycles, then `halt` → PC 0,1,2,3,4,5; `done`=1 the cycle after `halt`; PC held at 5.
- At PC=0x010: `rel_jump`=1, `taken`=1, `target`=0x1FD (−3) → PC=0x00D. Then `abs_jump`=1, `taken`=0 → PC=0x00E.
- PC=0x1FF with no control → PC=0x000 (wrap). Assert `stall` for 3 cycles with `abs_jump`/`taken` high → PC unchanged and `fetch_valid`=0.
- With `CALL_STACK_EN`: `call` to 0x080 from PC 0x020, then `ret` → PC 0x080, then 0x021. Five nested calls with depth 4 → fifth push dropped and `stack_err`=1.
- Simultaneous `halt`, `ret` and `call` at PC 0x030 → DONE, PC 0x030, stack depth unchanged.
